ldm_stm_seq: RTL and testbench
==============================

# ldm_stm_seq

Multi-register transfer sequencer for the multi-cycle core. The main control FSM hands off a decoded LDM/STM instruction (register list, base, P/U/W bits); this block walks the list lowest-register-first, issuing one memory word access per listed register, and optionally writes back the updated base. The main FSM stalls on `busy` and resumes on `done`. The block generalises the single-register LDR/STR path to NREG-wide lists with a memory-ready handshake.

## Interface
Parameters:
- `NREG`, 16: register list width; register index width `RW = $clog2(NREG)`.
- `AW`, 32: address/data width; word stride is 4.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  launch request; sampled only in IDLE.
- `load`  in  1  1 = LDM, 0 = STM.
- `P`, `U`, `W`  in  1 each  pre-index, up, base writeback.
- `reg_list`  in  NREG  bit i set = transfer register i.
- `rn`  in  RW  base register index.
- `base`  in  AW  base register value.
- `mem_ready`  in  1  memory accepts/completes the current beat.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle completion pulse.
- `mem_req`  out  1  access request.
- `mem_we`  out  1  write strobe (STM beats).
- `mem_addr`  out  AW  word address of current beat.
- `reg_idx`  out  RW  register for current beat; `rn` during WB.
- `write_reg`  out  1  register-file write enable.
- `wb_sel`  out  1  0 = memory read data, 1 = `wb_data`.
- `wb_data`  out  AW  updated base value.

## Operation
- States: IDLE, SETUP, XFER, WB, DONE.
- IDLE: `start`=1 → SETUP; `load`, P, U, W, `reg_list`, `rn`, `base` latched this cycle; later input changes ignored until the next IDLE.
- SETUP: n = popcount(list). Start address: IA (P=0,U=1) base; IB (P=1,U=1) base+4; DA (P=0,U=0) base−4n+4; DB (P=1,U=0) base−4n. New base = U ? base+4n : base−4n. n=0 → WB if W else DONE; otherwise → XFER with `reg_idx` = lowest set bit.
- XFER: `mem_req`=1, `mem_we`=!load. On `mem_ready`: if load, `write_reg`=1, `wb_sel`=0 in that same cycle (combinational on `mem_ready`); clear the current list bit; `mem_addr` += 4; `reg_idx` = next set bit. After the last beat → WB if W (and not suppressed) else DONE. `mem_ready`=0 holds `mem_addr`, `reg_idx` and the request unchanged.
- WB: `write_reg`=1, `wb_sel`=1, `reg_idx`=`rn`, `wb_data`=new base; one cycle → DONE. Suppressed (skip to DONE) when load=1 and `reg_list[rn]`=1: the loaded value wins.
- DONE: `done`=1 one cycle → IDLE.
- Arithmetic modulo 2^AW; address wrap-around is silent.
- `start` while busy: ignored, not queued.

## Timing
- Reset: state IDLE; `busy`, `done`, `mem_req`, `mem_we`, `write_reg`, `wb_sel` = 0; `mem_addr`, `reg_idx`, `wb_data` = 0.
- `rst` mid-operation: next cycle IDLE with reset values; the in-flight beat is abandoned with no write.
- `start` at cycle t → SETUP t+1 → first beat t+2. With zero wait states and n registers: WB at t+n+2, `done` at t+n+3 (W=1); `done` at t+n+2 (W=0 or suppressed).
- Each wait cycle on `mem_ready` delays all later events by one cycle.
- Beat completes in the cycle `mem_ready`=1 while `mem_req`=1; `mem_ready` outside XFER is ignored.

## Configuration
- `LDM_STM_WRITEBACK_EN` defined: W honoured, WB state present as above.
- Undefined: no WB state, W ignored, `wb_sel` and `wb_data` tied 0; `write_reg` fires only on LDM beats; `done` at t+n+2 regardless of W.

## Test plan
- LDMIA base=0x100, list=0x000F, rn=5, W=1, ready=1 → addrs 0x100/0x104/0x108/0x10C with `write_reg` and `reg_idx` 0..3; WB `reg_idx`=5, `wb_data`=0x110; `done` at t+7.
- STMDB base=0x200, list=0x4010, W=1 → `mem_we`=1, addr 0x1F8 (`reg_idx`=4), 0x1FC (`reg_idx`=14); no data `write_reg`; WB `wb_data`=0x1F8.
- LDMIA list=0x0003 with `mem_ready` low for 3 cycles on the first beat → addr 0x100 and `reg_idx`=0 held 4 cycles, single `write_reg` on the ready cycle; `done` 3 cycles later than zero-wait.
- Empty list, W=1, base=0x40 → no `mem_req`; WB `wb_data`=0x40; `done` at t+3.
- LDMIB base=0xFFFFFFFC, list=0x0003, rn=0, W=1 → addrs 0x00000000, 0x00000004 (wrap); WB suppressed; `done` at t+4.
- `rst` asserted during the second XFER beat → next cycle all outputs at reset values; a fresh `start` runs a full correct transfer.

Source files
------------

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: multi-register transfer sequencer for LDM/STM.
// Walks a latched register list lowest-index-first, issuing one word
// access per listed register, then optionally writes back the updated base.
//
// Build option: define LDM_STM_WRITEBACK_EN to honour W and include the
// base writeback (WB) state. Without it W is ignored, wb_sel/wb_data are
// tied low and write_reg only fires on LDM data beats.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the start cycle
// SETUP | count list, form start address and new base, pick first reg
// XFER  | one memory beat per listed register, advances on mem_ready
// WB    | write updated base into rn (skipped if rn was loaded)
// DONE  | one-cycle completion pulse back to the main FSM

module ldm_stm_seq #(
  parameter  int NREG = 16,
  parameter  int AW   = 32,
  localparam int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            load,
  input  logic            P,
  input  logic            U,
  input  logic            W,
  input  logic [NREG-1:0] reg_list,
  input  logic [RW-1:0]   rn,
  input  logic [AW-1:0]   base,
  input  logic            mem_ready,
  output logic            busy,
  output logic            done,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [RW-1:0]   reg_idx,
  output logic            write_reg,
  output logic            wb_sel,
  output logic [AW-1:0]   wb_data
);

  localparam logic [AW-1:0] STRIDE = AW'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_WB,
    S_DONE
  } state_t;

  // Number of set bits in a register list, already widened to address width.
  function automatic logic [AW-1:0] f_popcount(input logic [NREG-1:0] v);
    logic [AW-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + AW'(v[i]);
    end
    return c;
  endfunction

  // Index of the lowest set bit; zero for an empty list.
  function automatic logic [RW-1:0] f_lowest(input logic [NREG-1:0] v);
    logic [RW-1:0] r;
    r = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = RW'(i);
      end
    end
    return r;
  endfunction

  state_t          r_state;
  logic            r_load;
  logic            r_p;
  logic            r_u;
  logic            r_w;
  logic [NREG-1:0] r_list;
  logic [RW-1:0]   r_rn;
  logic [AW-1:0]   r_base;
  logic            r_wb_go;
  logic            r_busy;
  logic            r_done;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [RW-1:0]   r_reg_idx;
  logic            r_wr_wb;
  logic            r_wb_sel;
`ifdef LDM_STM_WRITEBACK_EN
  logic [AW-1:0]   r_wb_data;
`endif

  logic            w_w_eff;
  logic            w_wb_go;
  logic [AW-1:0]   w_four_n;
  logic [AW-1:0]   w_start_addr;
  logic [AW-1:0]   w_new_base;
  logic [RW-1:0]   w_first_idx;
  logic            w_list_empty;
  logic [NREG-1:0] w_list_rest;
  logic [RW-1:0]   w_next_idx;
  logic            w_last;

`ifdef LDM_STM_WRITEBACK_EN
  assign w_w_eff = W;
`else
  // Writeback compiled out: W has no effect, so the WB state is unreachable.
  logic w_unused;
  assign w_w_eff  = 1'b0;
  assign w_unused = ^{W, r_wb_sel, w_new_base};
`endif

  // When rn is in an LDM list the loaded word is the final value of rn.
  assign w_wb_go = r_w & ~(r_load & r_list[r_rn]);

  assign w_four_n     = f_popcount(r_list) << 2;
  assign w_new_base   = r_u ? (r_base + w_four_n) : (r_base - w_four_n);
  assign w_first_idx  = f_lowest(r_list);
  assign w_list_empty = (r_list == '0);

  // Lowest address of the block in every mode; beats always ascend by 4.
  always_comb begin
    w_start_addr = r_base;
    case ({r_p, r_u})
      2'b01:   w_start_addr = r_base;
      2'b11:   w_start_addr = r_base + STRIDE;
      2'b00:   w_start_addr = r_base - w_four_n + STRIDE;
      default: w_start_addr = r_base - w_four_n;
    endcase
  end

  assign w_list_rest = r_list & ~(NREG'(1) << r_reg_idx);
  assign w_next_idx  = f_lowest(w_list_rest);
  assign w_last      = (w_list_rest == '0);

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_load     <= 1'b0;
      r_p        <= 1'b0;
      r_u        <= 1'b0;
      r_w        <= 1'b0;
      r_list     <= '0;
      r_rn       <= '0;
      r_base     <= '0;
      r_wb_go    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_reg_idx  <= '0;
      r_wr_wb    <= 1'b0;
      r_wb_sel   <= 1'b0;
`ifdef LDM_STM_WRITEBACK_EN
      r_wb_data  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SETUP;
            r_busy  <= 1'b1;
            r_load  <= load;
            r_p     <= P;
            r_u     <= U;
            r_w     <= w_w_eff;
            r_list  <= reg_list;
            r_rn    <= rn;
            r_base  <= base;
          end
        end

        S_SETUP: begin
          r_wb_go <= w_wb_go;
`ifdef LDM_STM_WRITEBACK_EN
          r_wb_data <= w_new_base;
`endif
          if (w_list_empty) begin
            if (w_wb_go) begin
              r_state   <= S_WB;
              r_wr_wb   <= 1'b1;
              r_wb_sel  <= 1'b1;
              r_reg_idx <= r_rn;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_state    <= S_XFER;
            r_mem_req  <= 1'b1;
            r_mem_we   <= ~r_load;
            r_mem_addr <= w_start_addr;
            r_reg_idx  <= w_first_idx;
          end
        end

        S_XFER: begin
          // Without mem_ready the beat, address and index simply hold.
          if (mem_ready) begin
            r_list     <= w_list_rest;
            r_mem_addr <= r_mem_addr + STRIDE;
            if (w_last) begin
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              if (r_wb_go) begin
                r_state   <= S_WB;
                r_wr_wb   <= 1'b1;
                r_wb_sel  <= 1'b1;
                r_reg_idx <= r_rn;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_reg_idx <= w_next_idx;
            end
          end
        end

        S_WB: begin
          r_state  <= S_DONE;
          r_wr_wb  <= 1'b0;
          r_wb_sel <= 1'b0;
          r_done   <= 1'b1;
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_req  = r_mem_req;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign reg_idx  = r_reg_idx;

  // LDM data writes follow mem_ready in the same cycle; a beat caught by
  // reset is dropped rather than committed to the register file.
  assign write_reg = ~rst & (r_wr_wb | (r_mem_req & r_load & mem_ready));

`ifdef LDM_STM_WRITEBACK_EN
  assign wb_sel  = r_wb_sel;
  assign wb_data = r_wb_data;
`else
  assign wb_sel  = 1'b0;
  assign wb_data = '0;
`endif

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: directed scenarios plus randomized
// transfers, each compared cycle by cycle against the expected beat list.
module tb_ldm_stm_seq;

`ifdef LDM_STM_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        load = 1'b0;
  logic        p_b = 1'b0;
  logic        u_b = 1'b0;
  logic        w_b = 1'b0;
  logic [15:0] reg_list = '0;
  logic [3:0]  rn = '0;
  logic [31:0] base = '0;
  logic        mem_ready = 1'b0;
  logic        busy, done, mem_req, mem_we, write_reg, wb_sel;
  logic [31:0] mem_addr, wb_data;
  logic [3:0]  reg_idx;

  int n_vec = 0;
  int n_err = 0;

  ldm_stm_seq #(.NREG(16), .AW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .load(load),
    .P(p_b), .U(u_b), .W(w_b), .reg_list(reg_list), .rn(rn), .base(base),
    .mem_ready(mem_ready), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .reg_idx(reg_idx),
    .write_reg(write_reg), .wb_sel(wb_sel), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Launch one transfer and follow it to the IDLE cycle after done.
  // exp_done: zero-wait done cycle relative to the start edge (-1 = derive).
  task automatic run_xfer(input string nm, input bit ld, input bit pp,
                          input bit uu, input bit ww, input logic [15:0] lst,
                          input logic [3:0] rnv, input logic [31:0] bs,
                          input int first_waits, input int wait_pct,
                          input int exp_done);
    int idxq[$];
    int n, k, el, waits, stalls, done_el, ph, req_done;
    logic [31:0] sa, newb, four_n;
    logic [4:0] got, exp;
    bit wb_left, finished, wb_exp;
    for (int i = 0; i < 16; i++) if (lst[i]) idxq.push_back(i);
    n = idxq.size();
    four_n = 32'(4 * n);
    case ({pp, uu})
      2'b01:   sa = bs;
      2'b11:   sa = bs + 32'd4;
      2'b00:   sa = bs - four_n + 32'd4;
      default: sa = bs - four_n;
    endcase
    newb = uu ? bs + four_n : bs - four_n;
    wb_exp = WB_EN && ww && !(ld && lst[rnv]);

    load = ld; p_b = pp; u_b = uu; w_b = ww; reg_list = lst; rn = rnv;
    base = bs; start = 1'b1; mem_ready = 1'($urandom);
    @(posedge clk);
    el = 0; k = 0; waits = 0; stalls = 0; done_el = -1;
    wb_left = wb_exp; finished = 1'b0;
    while (!finished && el < 400) begin
      #1;
      el++;
      if (el == 1) ph = 0;
      else if (k < n) ph = 1;
      else if (wb_left) ph = 2;
      else if (done_el < 0) ph = 3;
      else ph = 4;
      start = (ph == 4) ? 1'b0 : 1'($urandom);
      load = 1'($urandom); p_b = 1'($urandom); u_b = 1'($urandom);
      w_b = 1'($urandom); reg_list = 16'($urandom); rn = 4'($urandom);
      base = $urandom;
      if (ph == 1) begin
        if (k == 0 && stalls < first_waits) begin
          mem_ready = 1'b0;
          stalls++;
        end else begin
          mem_ready = ($urandom_range(0, 99) >= wait_pct);
        end
      end else begin
        mem_ready = 1'($urandom);
      end
      @(negedge clk);
      got = {busy, done, mem_req, mem_we, write_reg};
      case (ph)
        0:       exp = 5'b10000;
        1:       exp = {1'b1, 1'b0, 1'b1, !ld, ld && mem_ready};
        2:       exp = 5'b10001;
        3:       exp = 5'b11000;
        default: exp = 5'b00000;
      endcase
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s ctl(busy,done,req,we,wr) cyc=%0d got=%b exp=%b", nm, el, got, exp);
      end
      if (ph == 1) begin
        n_vec++;
        if (mem_addr !== sa + 32'(4 * k) || reg_idx !== 4'(idxq[k])) begin
          n_err++;
          $display("FAIL %s beat%0d addr/idx got=%h/%0d exp=%h/%0d", nm, k,
                   mem_addr, reg_idx, sa + 32'(4 * k), idxq[k]);
        end
        if (write_reg) begin
          n_vec++;
          if (wb_sel !== 1'b0) begin
            n_err++;
            $display("FAIL %s beat%0d wb_sel got=%b exp=0", nm, k, wb_sel);
          end
        end
      end
      if (ph == 2) begin
        n_vec++;
        if (wb_sel !== 1'b1 || reg_idx !== rnv || wb_data !== newb) begin
          n_err++;
          $display("FAIL %s wb sel/idx/data got=%b/%0d/%h exp=1/%0d/%h", nm,
                   wb_sel, reg_idx, wb_data, rnv, newb);
        end
      end
      if (ph == 1) begin
        if (mem_ready) k++;
        else waits++;
      end
      if (ph == 2) wb_left = 1'b0;
      if (ph == 3) done_el = el;
      if (ph == 4) finished = 1'b1;
      @(posedge clk);
    end
    if (!finished) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout got=%0d cycles exp=completion", nm, el);
    end else begin
      req_done = ((exp_done >= 0) ? exp_done : n + 2 + int'(wb_exp)) + waits;
      n_vec++;
      if (done_el != req_done) begin
        n_err++;
        $display("FAIL %s done_cycle got=t+%0d exp=t+%0d", nm, done_el, req_done);
      end
    end
    #1;
    start = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [75:0] outs;
    rst = 1'b1; start = 1'b1; mem_ready = 1'b1; load = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {busy, done, mem_req, mem_we, write_reg, wb_sel, mem_addr, reg_idx, wb_data};
    n_vec++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, done, mem_req} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle got=%b exp=000", {busy, done, mem_req});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ldmia;
    run_xfer("ldmia", 1, 0, 1, 1, 16'h000F, 4'd5, 32'h100, 0, 0, WB_EN ? 7 : 6);
  endtask

  task automatic test_stmdb;
    run_xfer("stmdb", 0, 1, 0, 1, 16'h4010, 4'd13, 32'h200, 0, 0, WB_EN ? 5 : 4);
  endtask

  task automatic test_wait_states;
    run_xfer("wait3", 1, 0, 1, 0, 16'h0003, 4'd5, 32'h100, 3, 0, 4);
  endtask

  task automatic test_empty_list;
    run_xfer("empty", 1, 0, 1, 1, 16'h0000, 4'd2, 32'h40, 0, 0, WB_EN ? 3 : 2);
  endtask

  task automatic test_wrap_suppress;
    run_xfer("ldmib_wrap", 1, 1, 1, 1, 16'h0003, 4'd0, 32'hFFFF_FFFC, 0, 0, 4);
  endtask

  task automatic test_midop_reset;
    load = 1'b1; p_b = 1'b0; u_b = 1'b1; w_b = 1'b1; reg_list = 16'h000F;
    rn = 4'd5; base = 32'h100; mem_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h104 || reg_idx !== 4'd1 || write_reg !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_beat2 req/addr/idx/wr got=%b/%h/%0d/%b exp=1/104/1/0",
               mem_req, mem_addr, reg_idx, write_reg);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, done, mem_req, mem_we, write_reg, wb_sel, mem_addr, reg_idx, wb_data} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs got busy=%b req=%b wr=%b addr=%h idx=%0d exp=all 0",
               busy, mem_req, write_reg, mem_addr, reg_idx);
    end
    @(posedge clk);
    #1 mem_ready = 1'b0;
    run_xfer("after_rst", 1, 0, 1, 1, 16'h000F, 4'd5, 32'h100, 0, 0, WB_EN ? 7 : 6);
  endtask

  task automatic test_random;
    logic [15:0] lst;
    logic [31:0] bs;
    for (int i = 0; i < 40; i++) begin
      lst = 16'($urandom);
      if ($urandom_range(0, 3) == 0) lst = lst & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 9) == 0) lst = '0;
      bs = $urandom;
      if ($urandom_range(0, 3) == 0) bs = 32'hFFFF_FFC0 + 32'($urandom_range(0, 127));
      run_xfer("random", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               lst, 4'($urandom), bs, 0, 30, -1);
    end
  endtask

  initial begin
    test_reset();
    test_ldmia();
    test_stmdb();
    test_wait_states();
    test_empty_list();
    test_wrap_suppress();
    test_midop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
